// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM with PC update, branch/jump resolution and misaligned-target halt
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic [3:0]  bxx,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] alu_result,
    output logic        halted
);
    typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc;
    logic        halted_q, halted_d, taken;
    // branch condition selected by funct3 from the ALU compare result
    always_comb begin
        taken = 1'b0;
        case (bxx[2:0])
            3'b000:         taken = alu_result == 32'd0;
            3'b001:         taken = alu_result != 32'd0;
            3'b100, 3'b110: taken = alu_result[0];
            3'b101, 3'b111: taken = ~alu_result[0];
            default:        taken = 1'b0;
        endcase
    end
    // target selection: jal over jalr over taken branch over fall-through
    always_comb begin
        next_pc = jal              ? pc_q + imm :
                  jalr             ? (rs1_data + imm) & ~32'd1 :
                  (bxx[3] && taken) ? pc_q + imm : pc_q + 32'd4;
    end
    // handshake sequencing; responses matter only in WAIT, commit only in EXEC
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        case (state_q)
            FETCH: if (imem_req_ready) state_d = WAIT;
            WAIT: begin
                if (imem_resp_valid) begin
                    state_d = EXEC;
                    instr_d = imem_resp_data;
                end
            end
            EXEC: begin
                if (commit) begin
                    pc_d     = next_pc;
                    halted_d = next_pc[1:0] != 2'b00;
                    state_d  = (next_pc[1:0] != 2'b00) ? HALT : FETCH;
                end
            end
            default: state_d = HALT;
        endcase
    end
    // state registers; reset drops any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
        end
    end
    assign imem_req_valid = (state_q == FETCH) && !rst;
    assign instr_valid    = (state_q == EXEC) && !rst;
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign instr          = instr_q;
    assign halted         = halted_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scenario tasks plus randomized instruction stream against a PC model
module tb_if_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid, instr_valid, commit, jal, jalr, halted;
    logic [31:0] imem_req_addr, imem_resp_data, instr, pc, pc_plus4, imm, rs1_data, alu_result;
    logic [3:0]  bxx;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] m_pc;
    logic        m_halt;

    if_stage dut (
        .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .commit(commit),
        .bxx(bxx), .jal(jal), .jalr(jalr), .imm(imm), .rs1_data(rs1_data), .alu_result(alu_result),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // where the program counter goes after an instruction, straight from the ISA rules
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [3:0] b, input logic j,
                                             input logic jr, input logic [31:0] im, input logic [31:0] r1,
                                             input logic [31:0] alu);
        logic t;
        case (b[2:0])
            3'b000:         t = (alu == 0);
            3'b001:         t = (alu != 0);
            3'b100, 3'b110: t = (alu % 2 == 1);
            3'b101, 3'b111: t = (alu % 2 == 0);
            default:        t = 1'b0;
        endcase
        if (j) return p + im;
        if (jr) return ((r1 + im) / 2) * 2;
        if (b[3] && t) return p + im;
        return p + 4;
    endfunction

    task automatic clr();
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0; commit = 0;
        bxx = 0; jal = 0; jalr = 0; imm = 0; rs1_data = 0; alu_result = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // one full instruction with zero-wait memory; starts and ends in FETCH (or HALT)
    task automatic issue(input logic [31:0] w, input logic [3:0] b, input logic j, input logic jr,
                         input logic [31:0] im, input logic [31:0] r1, input logic [31:0] alu);
        imem_req_ready = 1; step(); imem_req_ready = 0;
        imem_resp_valid = 1; imem_resp_data = w; step(); imem_resp_valid = 0;
        bxx = b; jal = j; jalr = jr; imm = im; rs1_data = r1; alu_result = alu; commit = 1;
        m_pc = ref_next(m_pc, b, j, jr, im, r1, alu);
        m_halt = (m_pc % 4 != 0);
        step(); clr();
    endtask

    task automatic test_reset();
        clr(); rst = 1; step();
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b exp 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_instr_valid: got %b exp 0", instr_valid); end
        step(); rst = 0; m_pc = 0; m_halt = 0;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h exp 0", pc); end
        n_cmp++; if (instr !== 32'h13) begin n_err++; $display("FAIL rst_instr: got %h exp 00000013", instr); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b exp 0", halted); end
        n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc_plus4: got %h exp 4", pc_plus4); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rst_release_req: got %b exp 1", imem_req_valid); end
    endtask

    task automatic test_first_fetch();
        imem_req_ready = 1;
        @(negedge clk);
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL ff_addr: got %h exp 0", imem_req_addr); end
        step(); imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = 32'h0010_0093;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL ff_wait: got req %b iv %b exp 0 0", imem_req_valid, instr_valid); end
        step(); imem_resp_valid = 0;
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL ff_instr_valid: got %b exp 1", instr_valid); end
        n_cmp++; if (instr !== 32'h0010_0093) begin n_err++; $display("FAIL ff_instr: got %h exp 00100093", instr); end
        commit = 1; step(); commit = 0; m_pc = 4;
        @(negedge clk);
        n_cmp++; if (imem_req_addr !== 32'h4 || pc_plus4 !== 32'h8) begin n_err++; $display("FAIL ff_advance: got addr %h p4 %h exp 4 8", imem_req_addr, pc_plus4); end
    endtask

    task automatic test_sequential();
        issue(32'h13, 4'h0, 1'b1, 1'b0, 32'h100 - m_pc, 0, 0);
        @(negedge clk);
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL seq_jal: got %h exp 00000100", pc); end
        issue(32'h13, 4'h0, 1'b0, 1'b0, 32'h0, 0, 0);
        @(negedge clk);
        n_cmp++; if (imem_req_addr !== 32'h104 || pc_plus4 !== 32'h108) begin n_err++; $display("FAIL seq_plus4: got addr %h p4 %h exp 104 108", imem_req_addr, pc_plus4); end
    endtask

    task automatic test_branch();
        issue(32'h63, 4'h0, 1'b1, 1'b0, 32'h20 - m_pc, 0, 0);
        issue(32'h63, 4'b1000, 1'b0, 1'b0, -32'sd8, 0, 32'd0);
        @(negedge clk);
        n_cmp++; if (pc !== 32'h18) begin n_err++; $display("FAIL beq_taken: got %h exp 00000018", pc); end
        issue(32'h63, 4'h0, 1'b1, 1'b0, 32'h8, 0, 0);
        issue(32'h63, 4'b1000, 1'b0, 1'b0, -32'sd8, 0, 32'd5);
        @(negedge clk);
        n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL beq_not_taken: got %h exp 00000024", pc); end
    endtask

    task automatic test_wrap();
        issue(32'h6f, 4'h0, 1'b1, 1'b0, 32'hFFFF_FFFC - m_pc, 0, 0);
        @(negedge clk);
        n_cmp++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_top: got pc %h p4 %h exp fffffffc 0", pc, pc_plus4); end
        issue(32'h13, 4'h0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        n_cmp++; if (imem_req_addr !== 32'h0 || halted !== 1'b0) begin n_err++; $display("FAIL wrap_zero: got addr %h halted %b exp 0 0", imem_req_addr, halted); end
    endtask

    task automatic test_stalls();
        for (int s = 0; s < 4; s++) begin
            imem_resp_valid = (s == 1); imem_resp_data = 32'hDEAD_BEEF;
            @(negedge clk);
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL stall_fetch: got req %b addr %h iv %b exp 1 %h 0", imem_req_valid, imem_req_addr, instr_valid, m_pc); end
            step();
        end
        imem_resp_valid = 0; imem_req_ready = 1; step(); imem_req_ready = 0;
        commit = 1; jal = 1; imm = 32'h40;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_wait: got req %b iv %b exp 0 0", imem_req_valid, instr_valid); end
        step(); clr();
        @(negedge clk);
        n_cmp++; if (pc !== m_pc || instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_commit_ignored: got pc %h iv %b exp %h 0", pc, instr_valid, m_pc); end
        imem_resp_valid = 1; imem_resp_data = 32'h1234_5678; step(); imem_resp_valid = 0;
        @(negedge clk);
        n_cmp++; if (instr !== 32'h1234_5678 || instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_instr: got %h iv %b exp 12345678 1", instr, instr_valid); end
        commit = 1; step(); commit = 0; m_pc = m_pc + 4;
        @(negedge clk);
        n_cmp++; if (imem_req_addr !== m_pc) begin n_err++; $display("FAIL stall_next: got %h exp %h", imem_req_addr, m_pc); end
    endtask

    task automatic test_reset_in_wait();
        imem_req_ready = 1; step(); imem_req_ready = 0;
        rst = 1; imem_resp_valid = 1; imem_resp_data = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_during: got req %b iv %b exp 0 0", imem_req_valid, instr_valid); end
        step(); rst = 0; clr(); m_pc = 0; m_halt = 0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rw_req: got req %b addr %h exp 1 0", imem_req_valid, imem_req_addr); end
        n_cmp++; if (instr !== 32'h13 || halted !== 1'b0) begin n_err++; $display("FAIL rw_state: got instr %h halted %b exp 00000013 0", instr, halted); end
    endtask

    task automatic test_jalr_halt();
        issue(32'h67, 4'h0, 1'b0, 1'b1, 32'h0, 32'h1003, 0);
        for (int s = 0; s < 4; s++) begin
            imem_req_ready = 1; imem_resp_valid = 1; commit = 1; jal = 1; imm = 4;
            @(negedge clk);
            n_cmp++; if (pc !== 32'h1002 || halted !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL jalr_halt: got pc %h halted %b req %b iv %b exp 00001002 1 0 0", pc, halted, imem_req_valid, instr_valid); end
            step();
        end
        clr(); rst = 1; step(); rst = 0; m_pc = 0; m_halt = 0;
    endtask

    task automatic test_random();
        logic [31:0] w, im, r1, alu;
        logic [3:0]  b;
        logic        j, jr;
        for (int k = 0; k < 120; k++) begin
            w = $urandom;
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                imem_resp_valid = 1'($urandom_range(0, 1)); imem_resp_data = $urandom;
                @(negedge clk);
                n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== m_pc) begin n_err++; $display("FAIL rnd_fetch_stall: got req %b addr %h exp 1 %h", imem_req_valid, imem_req_addr, m_pc); end
                step();
            end
            imem_resp_valid = 0; imem_req_ready = 1;
            @(negedge clk);
            n_cmp++; if (imem_req_addr !== m_pc || pc_plus4 !== m_pc + 4 || halted !== 1'b0) begin
                n_err++; $display("FAIL rnd_fetch: got addr %h p4 %h halted %b exp %h %h 0", imem_req_addr, pc_plus4, halted, m_pc, m_pc + 4); end
            step(); imem_req_ready = 0;
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                commit = 1'($urandom_range(0, 1)); jal = 1; imm = $urandom;
                @(negedge clk);
                n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rnd_wait: got req %b iv %b exp 0 0", imem_req_valid, instr_valid); end
                step(); clr();
            end
            imem_resp_valid = 1; imem_resp_data = w; step(); imem_resp_valid = 0;
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                imem_resp_valid = 1; imem_resp_data = ~w;
                @(negedge clk);
                n_cmp++; if (instr_valid !== 1'b1 || instr !== w || pc !== m_pc) begin n_err++; $display("FAIL rnd_exec_hold: got iv %b instr %h pc %h exp 1 %h %h", instr_valid, instr, pc, w, m_pc); end
                step(); imem_resp_valid = 0;
            end
            j  = ($urandom_range(0, 3) == 0);
            jr = ($urandom_range(0, 3) == 0);
            b  = 4'($urandom_range(0, 15));
            im = 32'($urandom_range(0, 511)) * 4 - 32'd1024 + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            r1 = ($urandom & ~32'd3) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            alu = $urandom_range(0, 1) ? 32'd0 : $urandom;
            bxx = b; jal = j; jalr = jr; imm = im; rs1_data = r1; alu_result = alu; commit = 1;
            @(negedge clk);
            n_cmp++; if (instr !== w || instr_valid !== 1'b1) begin n_err++; $display("FAIL rnd_instr: got %h iv %b exp %h 1", instr, instr_valid, w); end
            m_pc = ref_next(m_pc, b, j, jr, im, r1, alu);
            m_halt = (m_pc % 4 != 0);
            step(); clr();
            @(negedge clk);
            n_cmp++; if (pc !== m_pc || halted !== m_halt || imem_req_valid !== !m_halt) begin
                n_err++; $display("FAIL rnd_next: got pc %h halted %b req %b exp %h %b %b", pc, halted, imem_req_valid, m_pc, m_halt, !m_halt); end
            if (m_halt) begin
                rst = 1; step(); rst = 0; m_pc = 0; m_halt = 0;
            end
        end
    endtask

    initial begin
        clr();
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_wrap();
        test_stalls();
        test_reset_in_wait();
        test_jalr_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
Parameters:
REQ-001 RESET_PC, 32'h0000_0000, PC loaded on reset; SHALL be word aligned.
Ports:
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_addr  output  32  fetch address; SHALL equal pc.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_resp_valid  input  1  response data valid.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 instr  output  32  held instruction to the decoder.
REQ-010 instr_valid  output  1  instr and pc are valid for execution.
REQ-011 pc  output  32  address of the current instruction.
REQ-012 pc_plus4  output  32  pc+4, the link value for jal/jalr writeback.
REQ-013 commit  input  1  core finished the current instruction; advance the PC.
REQ-014 bxx  input  4  [3]=branch instruction, [2:0]=funct3.
REQ-015 jal, jalr  input  1 each  jump controls from the decoder.
REQ-016 imm  input  32  decoded immediate.
REQ-017 rs1_data  input  32  rs1 value for the jalr target.
REQ-018 alu_result  input  32  ALU output for the branch compare.
REQ-019 halted  output  1  sticky flag for a misaligned-target stop.

Function
REQ-020 States SHALL be FETCH, WAIT, EXEC and HALT.
REQ-021 FETCH: imem_req_valid=1. If imem_req_ready=1 -> WAIT; otherwise stay in FETCH with the address held stable.
REQ-022 WAIT: imem_req_valid=0. If imem_resp_valid=1, latch imem_resp_data into instr and go to EXEC; otherwise stay in WAIT.
REQ-023 imem_resp_valid SHALL be ignored in every state other than WAIT.
REQ-024 EXEC: instr_valid=1 and instr is held. If commit=0, stay in EXEC. If commit=1, pc<=next_pc; go to HALT if next_pc[1:0]!=0, else go to FETCH.
REQ-025 commit SHALL be ignored outside EXEC.
REQ-026 HALT: halted=1, no requests, instr_valid=0; only rst exits HALT. pc SHALL hold the faulting target.
REQ-027 Branch taken rule:
- funct3 000: alu_result==0.
- funct3 001: alu_result!=0.
- funct3 100/110: alu_result[0]==1.
- funct3 101/111: alu_result[0]==0.
- funct3 010/011: never taken.
REQ-028 next_pc priority:
- jal: pc+imm.
- jalr: (rs1_data+imm) with bit 0 forced to 0.
- bxx[3] and taken: pc+imm.
- otherwise: pc+4.
REQ-029 All adds SHALL be 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-030 The minimum issue interval SHALL be 3 cycles per instruction (FETCH, WAIT, EXEC), given zero-wait ready and response.
REQ-031 pc_plus4 SHALL be combinational pc+4 and valid in every state.

Reset
REQ-032 While rst=1 at a clock edge:
- pc<=RESET_PC;
- instr<=32'h0000_0013 (NOP);
- state<=FETCH;
- halted<=0.
REQ-033 During a cycle with rst=1, the outputs imem_req_valid and instr_valid SHALL be 0.
REQ-034 Reset mid-operation SHALL abandon any outstanding request; the instruction memory shares rst, so no stale response SHALL follow.
REQ-035 rst SHALL take priority over every other input.

Verification
REQ-036 Reset release, ready=1, response one cycle later with 32'h0010_0093 -> request addr 0; instr_valid=1 on the third cycle after release; instr=32'h0010_0093.
REQ-037 commit with no jump or branch at pc=0x100 -> next request addr 0x104; pc_plus4=0x108 after the update.
REQ-038 beq (bxx=4'b1000), alu_result=0, imm=-8, pc=0x20 -> pc=0x18. Same stimulus with alu_result=5 -> pc=0x24.
REQ-039 jalr with rs1_data=0x1003, imm=0 -> pc=0x1002, halted=1, no further imem_req_valid.
REQ-040 Handshake stalls:
- ready held 0 for 4 cycles -> addr stable, still FETCH.
- resp_valid pulsed during FETCH -> ignored.
- commit asserted during WAIT -> ignored.
REQ-041 rst asserted in WAIT -> next cycle imem_req_valid=1, addr=RESET_PC, instr=32'h0000_0013, halted=0.
